// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The requester (master) drives operands, flush and out_ready; the unit (slave) drives the rest.
interface alu_muldiv_if #(
  parameter int W = 32
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_lhs;
  logic [W-1:0] in_rhs;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;

  modport master (
    output flush, in_valid, in_op, in_lhs, in_rhs, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_lhs, in_rhs, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiplier and restoring divider
// on operand magnitudes, with sign fix-up after W iterations and early special-case results.
module alu_muldiv_unit #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  alu_muldiv_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_reg;
  logic [2:0]     op_reg;
  logic [W-1:0]   a_reg;        // multiplicand, or dividend shifting into quotient
  logic [W-1:0]   b_reg;        // multiplier (shifts right), or divisor
  logic [W-1:0]   rem_reg;
  logic [2*W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic           neg_q_reg;    // product/quotient negated at FIX
  logic           neg_r_reg;    // remainder negated at FIX
  logic [W-1:0]   result_reg;
  logic           valid_reg;

  // Accept-time decode
  logic           lhs_signed, rhs_signed, lhs_neg, rhs_neg;
  logic [W-1:0]   lhs_abs, rhs_abs;
  logic           div_zero, div_ovf;
  logic [W-1:0]   special_result;

  assign lhs_signed = (bus.in_op == 3'b001) || (bus.in_op == 3'b010) ||
                      (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
  assign rhs_signed = (bus.in_op == 3'b001) || (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
  assign lhs_neg    = lhs_signed && bus.in_lhs[W-1];
  assign rhs_neg    = rhs_signed && bus.in_rhs[W-1];
  assign lhs_abs    = lhs_neg ? -bus.in_lhs : bus.in_lhs;
  assign rhs_abs    = rhs_neg ? -bus.in_rhs : bus.in_rhs;

  assign div_zero = bus.in_op[2] && (bus.in_rhs == '0);
  assign div_ovf  = bus.in_op[2] && !bus.in_op[0] &&
                    (bus.in_lhs == {1'b1, {(W-1){1'b0}}}) && (bus.in_rhs == '1);

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = bus.in_op[1] ? bus.in_lhs : '1;
    else if (div_ovf)
      special_result = bus.in_op[1] ? '0 : bus.in_lhs;
  end

  // One iteration of each datapath
  logic [2*W-1:0] mul_addend, acc_next;
  logic [W:0]     rem_shift, rem_diff;
  logic           quo_bit;

  assign mul_addend = {{W{1'b0}}, a_reg} << cnt_reg;
  assign acc_next   = b_reg[0] ? acc_reg + mul_addend : acc_reg;
  assign rem_shift  = {rem_reg, a_reg[W-1]};
  assign rem_diff   = rem_shift - {1'b0, b_reg};
  assign quo_bit    = !rem_diff[W];

  // Sign fix-up and result selection
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   quo_fixed, rem_fixed, fix_result;

  assign prod_fixed = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fixed  = neg_q_reg ? -a_reg   : a_reg;
  assign rem_fixed  = neg_r_reg ? -rem_reg : rem_reg;

  always_comb begin
    fix_result = '0;
    case (op_reg)
      3'b000:                 fix_result = prod_fixed[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fixed[2*W-1:W];
      3'b100, 3'b101:         fix_result = quo_fixed;
      default:                fix_result = rem_fixed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (bus.flush) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            op_reg    <= bus.in_op;
            a_reg     <= lhs_abs;
            b_reg     <= rhs_abs;
            rem_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= lhs_neg ^ rhs_neg;
            neg_r_reg <= lhs_neg;
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (op_reg[2]) begin
            rem_reg <= quo_bit ? rem_diff[W-1:0] : rem_shift[W-1:0];
            a_reg   <= {a_reg[W-2:0], quo_bit};
          end else begin
            acc_reg <= acc_next;
            b_reg   <= b_reg >> 1;
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(W-1))
            state_reg <= FIX;
        end
        FIX: begin
          result_reg <= fix_result;
          valid_reg  <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.out_valid  = valid_reg;
  assign bus.out_result = result_reg;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: a W=32 and a W=64 instance driven from one vector table,
// plus hand-written flush, back-pressure and mid-operation reset sequences.
module tb_alu_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_if #(.W(32)) b32();
  alu_muldiv_if #(.W(64)) b64();

  alu_muldiv_unit #(.W(32), .CNT_W(6)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  alu_muldiv_unit #(.W(64), .CNT_W(7)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  typedef struct {
    logic        w64;
    string       name;
    logic [2:0]  op;
    logic [63:0] lhs;
    logic [63:0] rhs;
    logic [63:0] exp;
    int          lat;   // posedges after the accept edge until out_valid is seen
  } vec_t;

  vec_t vecs[22];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] res(input logic w64);
    return w64 ? b64.out_result : {32'b0, b32.out_result};
  endfunction
  function automatic logic vld(input logic w64);
    return w64 ? b64.out_valid : b32.out_valid;
  endfunction
  function automatic logic rdy(input logic w64);
    return w64 ? b64.in_ready : b32.in_ready;
  endfunction
  function automatic logic bsy(input logic w64);
    return w64 ? b64.busy : b32.busy;
  endfunction

  task automatic drive(input logic w64, input logic v, input logic [2:0] op,
                       input logic [63:0] l, input logic [63:0] r);
    if (w64) begin
      b64.in_valid = v; b64.in_op = op; b64.in_lhs = l; b64.in_rhs = r;
    end else begin
      b32.in_valid = v; b32.in_op = op; b32.in_lhs = l[31:0]; b32.in_rhs = r[31:0];
    end
  endtask

  // Presents a request and returns just after its accept edge, with the inputs scrambled.
  task automatic start_op(input logic w64, input logic [2:0] op,
                          input logic [63:0] l, input logic [63:0] r);
    bit ok = 1'b0;
    @(negedge clk);
    drive(w64, 1'b1, op, l, r);
    for (int i = 0; i < 200; i++) begin
      if (rdy(w64)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    drive(w64, 1'b0, op ^ 3'b011, ~l, ~r);
  endtask

  task automatic run_op(input logic w64, input string name, input logic [2:0] op,
                        input logic [63:0] l, input logic [63:0] r,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat = 0;
    start_op(w64, op, l, r);
    while (!vld(w64) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    $display("W=%0d %s op=%0d lhs=0x%0h rhs=0x%0h -> result=0x%0h after %0d cycles",
             w64 ? 64 : 32, name, op, l, r, res(w64), lat);
    check({name, " result"}, res(w64), exp);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold valid"}, 64'(vld(w64)), 64'd1);
      check({name, " hold result"}, res(w64), exp);
    end
    @(negedge clk);
    if (w64) b64.out_ready = 1'b1; else b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b64.out_ready = 1'b0; b32.out_ready = 1'b0;
    check({name, " valid cleared"}, 64'(vld(w64)), 64'd0);
  endtask

  initial begin
    logic seen;

    vecs[0]  = '{0, "MUL",       3'b000, 64'h7,          64'hFFFFFFFD, 64'hFFFFFFEB, 33};
    vecs[1]  = '{0, "MULH",      3'b001, 64'h80000000,   64'h80000000, 64'h40000000, 33};
    vecs[2]  = '{0, "MULHSU",    3'b010, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFF, 33};
    vecs[3]  = '{0, "MULHU",     3'b011, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFE, 33};
    vecs[4]  = '{0, "DIV",       3'b100, 64'hFFFFFFF9,   64'h2,        64'hFFFFFFFD, 33};
    vecs[5]  = '{0, "REM",       3'b110, 64'hFFFFFFF9,   64'h2,        64'hFFFFFFFF, 33};
    vecs[6]  = '{0, "DIVU",      3'b101, 64'd100,        64'd7,        64'd14,       33};
    vecs[7]  = '{0, "REMU",      3'b111, 64'd100,        64'd7,        64'd2,        33};
    vecs[8]  = '{0, "DIV neg",   3'b100, 64'd20,         64'hFFFFFFFD, 64'hFFFFFFFA, 33};
    vecs[9]  = '{0, "REM neg",   3'b110, 64'd20,         64'hFFFFFFFD, 64'd2,        33};
    vecs[10] = '{0, "DIVU by0",  3'b101, 64'h1234,       64'h0,        64'hFFFFFFFF, 0};
    vecs[11] = '{0, "REM by0",   3'b110, 64'h1234,       64'h0,        64'h1234,     0};
    vecs[12] = '{0, "DIV ovf",   3'b100, 64'h80000000,   64'hFFFFFFFF, 64'h80000000, 0};
    vecs[13] = '{0, "REM ovf",   3'b110, 64'h80000000,   64'hFFFFFFFF, 64'h0,        0};
    vecs[14] = '{1, "MUL",       3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65};
    vecs[15] = '{1, "MULH",      3'b001, 64'h8000000000000000, 64'h8000000000000000,
                 64'h4000000000000000, 65};
    vecs[16] = '{1, "MULHU",     3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'hFFFFFFFFFFFFFFFE, 65};
    vecs[17] = '{1, "DIV",       3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 65};
    vecs[18] = '{1, "REM",       3'b110, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 65};
    vecs[19] = '{1, "REMU",      3'b111, 64'd100, 64'd7, 64'd2, 65};
    vecs[20] = '{1, "DIVU by0",  3'b101, 64'h1234, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0};
    vecs[21] = '{1, "DIV ovf",   3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
                 64'h8000000000000000, 0};

    rst = 1'b1;
    b32.flush = 1'b0; b32.out_ready = 1'b0;
    b64.flush = 1'b0; b64.out_ready = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 3'b000, 64'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready",   64'(rdy(1'b0)), 64'd1);
    check("reset out_valid",  64'(vld(1'b0)), 64'd0);
    check("reset busy",       64'(bsy(1'b0)), 64'd0);
    check("reset out_result", res(1'b0),      64'd0);
    check("reset64 out_result", res(1'b1),    64'd0);

    foreach (vecs[i])
      run_op(vecs[i].w64, vecs[i].name, vecs[i].op, vecs[i].lhs, vecs[i].rhs,
             vecs[i].exp, vecs[i].lat, 0);

    // Flush ten cycles into a divide, with a competing request in the flush cycle
    start_op(1'b0, 3'b100, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1 check("flush busy before", 64'(bsy(1'b0)), 64'd1);
    @(negedge clk);
    b32.flush = 1'b1;
    drive(1'b0, 1'b1, 3'b000, 64'd5, 64'd5);
    @(posedge clk); #1;
    b32.flush = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
    check("flush in_ready", 64'(rdy(1'b0)), 64'd1);
    check("flush busy",     64'(bsy(1'b0)), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | vld(1'b0);
    end
    check("flush no out_valid", 64'(seen), 64'd0);
    run_op(1'b0, "MUL after flush", 3'b000, 64'd3, 64'd4, 64'd12, 33, 0);

    // Flush while a result waits in DONE drops it
    start_op(1'b0, 3'b101, 64'h1234, 64'h0);
    @(negedge clk); b32.flush = 1'b1;
    @(posedge clk); #1 b32.flush = 1'b0;
    check("flush in DONE valid", 64'(vld(1'b0)), 64'd0);

    // Back-pressure: result held for five cycles with out_ready low
    run_op(1'b0, "MULHU hold", 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, 5);

    // Reset in the middle of a multiply
    start_op(1'b0, 3'b000, 64'd7, 64'd9);
    repeat (5) @(posedge clk);
    #1 check("mid-calc busy", 64'(bsy(1'b0)), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst mid-calc out_result", res(1'b0),      64'd0);
    check("rst mid-calc out_valid",  64'(vld(1'b0)), 64'd0);
    check("rst mid-calc in_ready",   64'(rdy(1'b0)), 64'd1);
    check("rst mid-calc busy",       64'(bsy(1'b0)), 64'd0);
    run_op(1'b0, "DIVU after rst", 3'b101, 64'd100, 64'd7, 64'd14, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
